// File: rtl/truth_table_capture.sv
// Exhaustive-sweep response capture: drives every input vector, samples the observed output, builds and grades the truth table.
// Optional build macro TTC_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_capture #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 dut_in,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      stim_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      fail_idx,
  output logic                 pass
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   ONE_C       = CW'(1);
  localparam logic [N_IN-1:0] ONE_I       = N_IN'(1);
  localparam logic [N_IN:0]   ONE_M       = (N_IN + 1)'(1);
  localparam logic [N_IN-1:0] LAST_IDX    = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE_ST,
    SAMPLE_ST,
    DONE_ST
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] settle_cnt;
  logic          first_fail;
  logic          sample_miss;
  logic          last_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    sample_miss = (dut_in != expected[stim_out]);
    last_vec    = (stim_out == LAST_IDX);
    case (state)
      IDLE, DONE_ST: begin
        if (start) state_next = SETTLE_ST;
      end
      SETTLE_ST: begin
        if (settle_cnt == SETTLE_LAST) state_next = SAMPLE_ST;
      end
      SAMPLE_ST: begin
`ifdef TTC_STOP_ON_FAIL_EN
        if (last_vec || (sample_miss && !first_fail)) state_next = DONE_ST;
        else                                          state_next = SETTLE_ST;
`else
        if (last_vec) state_next = DONE_ST;
        else          state_next = SETTLE_ST;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // stim_out doubles as the sweep index, so it only moves on the SAMPLE-exit edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stim_out       <= '0;
      settle_cnt     <= '0;
      table_out      <= '0;
      mismatch_count <= '0;
      fail_idx       <= '0;
      first_fail     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE_ST: begin
          if (start) begin
            stim_out       <= '0;
            settle_cnt     <= '0;
            table_out      <= '0;
            mismatch_count <= '0;
            fail_idx       <= '0;
            first_fail     <= 1'b0;
          end
        end
        SETTLE_ST: begin
          settle_cnt <= settle_cnt + ONE_C;
        end
        SAMPLE_ST: begin
          table_out[stim_out] <= dut_in;
          if (sample_miss) begin
            mismatch_count <= mismatch_count + ONE_M;
            if (!first_fail) begin
              fail_idx   <= stim_out;
              first_fail <= 1'b1;
            end
          end
          if (state_next == SETTLE_ST) begin
            stim_out   <= stim_out + ONE_I;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SETTLE_ST) || (state == SAMPLE_ST);
  assign done = (state == DONE_ST);
  assign pass = done && (mismatch_count == '0);

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture (N_IN=3, SETTLE=2) observing u = (s2&s1)|s0 or a stuck-at-1 output.
// Expectations follow TTC_STOP_ON_FAIL_EN when the macro is defined.
module tb_truth_table_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       dut_in;
  logic [7:0] expected;
  logic [2:0] stim_out;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic [3:0] mismatch_count;
  logic [2:0] fail_idx;
  logic       pass;

  logic force_one;
  int   passed = 0;
  int   total  = 0;

  truth_table_capture #(.N_IN(3), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start), .dut_in(dut_in), .expected(expected),
    .stim_out(stim_out), .busy(busy), .done(done), .table_out(table_out),
    .mismatch_count(mismatch_count), .fail_idx(fail_idx), .pass(pass)
  );

  always #5 clk = ~clk;

  assign dut_in = force_one ? 1'b1 : ((stim_out[2] & stim_out[1]) | stim_out[0]);

  // Pulse start for one edge, then count edges until done; -1 means it never came
  task automatic run_sweep(output int cycles, output int busy_drops);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = -1;
    busy_drops = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin cycles = i; break; end
      if (!busy) busy_drops++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; force_one = 1'b0; expected = 8'h00;
    repeat (2) @(posedge clk); #1;
    total++; if ({stim_out, busy, done, pass} !== 6'b0) $display("[TB] FAIL reset_ctrl got stim=%0d busy=%b done=%b pass=%b want 0", stim_out, busy, done, pass); else passed++;
    total++; if ({table_out, mismatch_count, fail_idx} !== 15'b0) $display("[TB] FAIL reset_results got table=%h mm=%0d fidx=%0d want 0", table_out, mismatch_count, fail_idx); else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_pass_sweep;
    int cyc, drops;
    force_one = 1'b0; expected = 8'hEA;
    run_sweep(cyc, drops);
    total++; if (cyc !== 24) $display("[TB] FAIL pass_latency got %0d want 24", cyc); else passed++;
    total++; if (drops !== 0) $display("[TB] FAIL pass_busy got %0d idle cycles want 0", drops); else passed++;
    total++; if (table_out !== 8'hEA) $display("[TB] FAIL pass_table got %h want ea", table_out); else passed++;
    total++; if (mismatch_count !== 4'd0 || fail_idx !== 3'd0) $display("[TB] FAIL pass_counts got mm=%0d fidx=%0d want 0/0", mismatch_count, fail_idx); else passed++;
    total++; if (pass !== 1'b1 || busy !== 1'b0 || stim_out !== 3'd7) $display("[TB] FAIL pass_flags got pass=%b busy=%b stim=%0d want 1/0/7", pass, busy, stim_out); else passed++;
    repeat (3) @(posedge clk); #1;
    total++; if (done !== 1'b1 || table_out !== 8'hEA) $display("[TB] FAIL pass_hold got done=%b table=%h want 1/ea", done, table_out); else passed++;
  endtask

  task automatic test_single_mismatch;
    int cyc, drops;
    force_one = 1'b0; expected = 8'hEB;
    run_sweep(cyc, drops);
`ifdef TTC_STOP_ON_FAIL_EN
    total++; if (cyc !== 3 || table_out !== 8'h00) $display("[TB] FAIL mm1_run got cyc=%0d table=%h want 3/00", cyc, table_out); else passed++;
`else
    total++; if (cyc !== 24 || table_out !== 8'hEA) $display("[TB] FAIL mm1_run got cyc=%0d table=%h want 24/ea", cyc, table_out); else passed++;
`endif
    total++; if (mismatch_count !== 4'd1 || fail_idx !== 3'd0 || pass !== 1'b0) $display("[TB] FAIL mm1_result got mm=%0d fidx=%0d pass=%b want 1/0/0", mismatch_count, fail_idx, pass); else passed++;
  endtask

  task automatic test_first_fail_index;
    int cyc, drops;
    // Expected bits 2 and 5 flipped: first failure at index 2, two mismatches overall
    force_one = 1'b0; expected = 8'hCE;
    run_sweep(cyc, drops);
`ifdef TTC_STOP_ON_FAIL_EN
    total++; if (cyc !== 9 || table_out !== 8'h02 || stim_out !== 3'd2) $display("[TB] FAIL ffi_run got cyc=%0d table=%h stim=%0d want 9/02/2", cyc, table_out, stim_out); else passed++;
    total++; if (mismatch_count !== 4'd1 || fail_idx !== 3'd2) $display("[TB] FAIL ffi_result got mm=%0d fidx=%0d want 1/2", mismatch_count, fail_idx); else passed++;
`else
    total++; if (cyc !== 24 || table_out !== 8'hEA) $display("[TB] FAIL ffi_run got cyc=%0d table=%h want 24/ea", cyc, table_out); else passed++;
    total++; if (mismatch_count !== 4'd2 || fail_idx !== 3'd2) $display("[TB] FAIL ffi_result got mm=%0d fidx=%0d want 2/2", mismatch_count, fail_idx); else passed++;
`endif
    total++; if (pass !== 1'b0) $display("[TB] FAIL ffi_pass got %b want 0", pass); else passed++;
  endtask

  task automatic test_all_mismatch;
    int cyc, drops;
    force_one = 1'b1; expected = 8'h00;
    run_sweep(cyc, drops);
`ifdef TTC_STOP_ON_FAIL_EN
    total++; if (cyc !== 3 || table_out !== 8'h01 || stim_out !== 3'd0) $display("[TB] FAIL all_run got cyc=%0d table=%h stim=%0d want 3/01/0", cyc, table_out, stim_out); else passed++;
    total++; if (mismatch_count !== 4'd1 || fail_idx !== 3'd0) $display("[TB] FAIL all_counts got mm=%0d fidx=%0d want 1/0", mismatch_count, fail_idx); else passed++;
`else
    total++; if (cyc !== 24 || table_out !== 8'hFF) $display("[TB] FAIL all_run got cyc=%0d table=%h want 24/ff", cyc, table_out); else passed++;
    total++; if (mismatch_count !== 4'b1000 || fail_idx !== 3'd0) $display("[TB] FAIL all_counts got mm=%0d fidx=%0d want 8/0", mismatch_count, fail_idx); else passed++;
`endif
    total++; if (pass !== 1'b0) $display("[TB] FAIL all_pass got %b want 0", pass); else passed++;
  endtask

  task automatic test_restart_from_done;
    int cyc;
    // Previous sweep left nonzero results; a start in DONE must wipe them
    force_one = 1'b0; expected = 8'hEA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b1 || stim_out !== 3'd0) $display("[TB] FAIL restart_ctrl got done=%b busy=%b stim=%0d want 0/1/0", done, busy, stim_out); else passed++;
    total++; if (table_out !== 8'h00 || mismatch_count !== 4'd0) $display("[TB] FAIL restart_clear got table=%h mm=%0d want 00/0", table_out, mismatch_count); else passed++;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; break; end
    end
    total++; if (cyc !== 24 || pass !== 1'b1) $display("[TB] FAIL restart_finish got cyc=%0d pass=%b want 24/1", cyc, pass); else passed++;
  endtask

  task automatic test_start_while_busy;
    int cyc;
    force_one = 1'b0; expected = 8'hEA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      if (i == 5) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 5) begin
        total++; if (stim_out !== 3'd1 || busy !== 1'b1) $display("[TB] FAIL busy_start_stim got stim=%0d busy=%b want 1/1", stim_out, busy); else passed++;
      end
      if (done) begin cyc = i; break; end
    end
    total++; if (cyc !== 24 || table_out !== 8'hEA) $display("[TB] FAIL busy_start_latency got cyc=%0d table=%h want 24/ea", cyc, table_out); else passed++;
  endtask

  task automatic test_reset_mid_sweep;
    int cyc, drops;
    force_one = 1'b0; expected = 8'hEA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    total++; if (table_out !== 8'h02 || stim_out !== 3'd3) $display("[TB] FAIL midsweep_progress got table=%h stim=%0d want 02/3", table_out, stim_out); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({stim_out, busy, done, table_out, mismatch_count} !== 17'b0) $display("[TB] FAIL midsweep_reset got stim=%0d busy=%b done=%b table=%h mm=%0d want 0", stim_out, busy, done, table_out, mismatch_count); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL midsweep_idle got busy=%b done=%b want 0/0", busy, done); else passed++;
    run_sweep(cyc, drops);
    total++; if (cyc !== 24 || table_out !== 8'hEA || pass !== 1'b1) $display("[TB] FAIL midsweep_rerun got cyc=%0d table=%h pass=%b want 24/ea/1", cyc, table_out, pass); else passed++;
  endtask

  initial begin
    test_reset();
    test_pass_sweep();
    test_single_mismatch();
    test_first_fail_index();
    test_all_mismatch();
    test_restart_from_done();
    test_start_while_busy();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
